// File: rtl/ldpc_pkg.sv
// rtl/ldpc_pkg.sv - shared H2 dimensions and multiply-stage state type
package ldpc_pkg;

  localparam int H2_ROWS = 27;
  localparam int H2_COLS = 162;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } h2m_state_t;

endpackage

// File: rtl/gf2_dot.sv
// rtl/gf2_dot.sv - GF(2) dot product: AND two vectors, XOR-reduce to one bit
module gf2_dot #(
  parameter int W = 162
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         y
);

  assign y = ^(a & b);

endmodule

// File: rtl/h2_parity_mult.sv
// rtl/h2_parity_mult.sv - serial GF(2) H2 x vector multiply, RPC rows per cycle
module h2_parity_mult
  import ldpc_pkg::*;
#(
  parameter int ROWS = H2_ROWS,
  parameter int COLS = H2_COLS,
  parameter int RPC  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [COLS-1:0] h2 [ROWS],
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [COLS-1:0] in_vec,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ROWS-1:0] out_par,
  output logic            busy
);

  localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - RPC);

  if (RPC < 1 || (ROWS % RPC) != 0) begin : g_bad_rpc
    $error("h2_parity_mult: RPC must divide ROWS");
  end

  h2m_state_t      state_q, state_d;
  logic [CW-1:0]   row_cnt_q, row_cnt_d;
  logic [COLS-1:0] vec_q, vec_d;
  logic [ROWS-1:0] acc_q, acc_d;

  logic [CW-1:0]   ridx [RPC];
  logic [RPC-1:0]  dot;

  // h2 is read live during CALC; the loader guarantees it is stable for the job
  for (genvar k = 0; k < RPC; k++) begin : g_dot
    assign ridx[k] = row_cnt_q + CW'(k);
    gf2_dot #(.W(COLS)) u_dot (
      .a (h2[ridx[k]]),
      .b (vec_q),
      .y (dot[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      row_cnt_q <= '0;
      vec_q     <= '0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      vec_q     <= vec_d;
      acc_q     <= acc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = CALC;
      CALC:    if (row_cnt_q == LAST_ROW) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    row_cnt_d = row_cnt_q;
    vec_d     = vec_q;
    acc_d     = acc_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          vec_d     = in_vec;
          acc_d     = '0;
          row_cnt_d = '0;
        end
      end
      CALC: begin
        for (int k = 0; k < RPC; k++) begin
          acc_d[ridx[k]] = dot[k];
        end
        if (row_cnt_q != LAST_ROW) row_cnt_d = row_cnt_q + CW'(RPC);
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    out_par   = (state_q == DONE) ? acc_q : '0;
    busy      = (state_q != IDLE);
  end

endmodule
